// File: rtl/mmcm_pkg.sv
// Shared types and helpers for the MMCM clock-enable generator.
package mmcm_pkg;

  // Lock-wait FSM states.
  typedef enum logic {
    StWait = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Width of a counter that can hold 0..lock_cycles inclusive.
  function automatic int unsigned lock_cnt_width(input int unsigned lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/cegen_acc.sv
// Single-channel phase accumulator producing a carry enable and a half-phase strobe.
module cegen_acc
  import mmcm_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter logic [W-1:0] INC = '0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic halt_i,
  output logic ce_o,
  output logic ceh_o
);

  // Increments of half a turn or more would otherwise strobe on every carry-free step.
  localparam logic HalfOk = ~INC[W-1];

  logic [W-1:0] acc_q, acc_d;
  logic         ce_q, ce_d;
  logic         ceh_q, ceh_d;
  logic [W:0]   sum;

  // Next accumulator value and strobes; clear beats halt, halt beats the update.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, INC};
    acc_d = acc_q;
    ce_d  = 1'b0;
    ceh_d = 1'b0;
    if (clr_i) begin
      acc_d = '0;
    end else if (!halt_i) begin
      acc_d = sum[W-1:0];
      ce_d  = sum[W];
      ceh_d = HalfOk & ~acc_q[W-1] & sum[W-1] & ~sum[W];
    end
  end

  // Accumulator and registered strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
      ceh_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
      ceh_q <= ceh_d;
    end
  end

  assign ce_o  = ce_q;
  assign ceh_o = ceh_q;

endmodule

// File: rtl/mmcm_cegen.sv
// Fractional-rate clock-enable generator gated by a debounced MMCM lock.
module mmcm_cegen
  import mmcm_pkg::*;
#(
  parameter int unsigned     N           = 2,
  parameter int unsigned     W           = 16,
  parameter logic [N*W-1:0]  INC         = {16'h4000, 16'h8000},
  parameter int unsigned     LOCK_CYCLES = 16
) (
  input  logic         ci_i,
  input  logic         reset_ni,
  input  logic         locked_i,
  input  logic         sync_i,
  input  logic [N-1:0] halt_i,
  output logic [N-1:0] ce_o,
  output logic [N-1:0] ceh_o,
  output logic         ready_o
);

  localparam int unsigned   CntW    = lock_cnt_width(LOCK_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(LOCK_CYCLES);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            go;
  logic            acc_clr;

  // Lock-wait FSM: count consecutive locked cycles, drop back on any loss of lock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go      = 1'b0;
    unique case (state_q)
      StWait: begin
        if (locked_i) begin
          if (cnt_q == CntLast) begin
            state_d = StRun;
            go      = 1'b1;
          end
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      StRun: begin
        if (!locked_i) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StWait;
        cnt_d   = '0;
      end
    endcase
  end

  // State and lock counter registers.
  always_ff @(posedge ci_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StWait;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The entry edge into RUN already performs the first accumulator update, so that
  // the first carry lands on RUN cycle ceil(2^W/INC).
  assign acc_clr = ~locked_i | sync_i | ((state_q == StWait) & ~go);
  assign ready_o = (state_q == StRun);

  for (genvar i = 0; i < N; i++) begin : g_ch
    cegen_acc #(
      .W  (W),
      .INC(INC[i*W +: W])
    ) u_acc (
      .clk_i (ci_i),
      .rst_ni(reset_ni),
      .clr_i (acc_clr),
      .halt_i(halt_i[i]),
      .ce_o  (ce_o[i]),
      .ceh_o (ceh_o[i])
    );
  end

endmodule

// File: tb/tb_mmcm_cegen.sv
// Self-checking bench for mmcm_cegen: a 2-channel W=16 instance and a 1-channel W=8 instance.
module tb_mmcm_cegen;

  localparam int LcM = 16;
  localparam int LcF = 4;

  logic       ci = 1'b0;
  logic       reset_n = 1'b0;
  logic       locked = 1'b0;
  logic       sync = 1'b0;
  logic [1:0] halt_m = 2'b00;
  logic [0:0] halt_f = 1'b0;
  logic [1:0] ce_m, ceh_m;
  logic       ready_m;
  logic [0:0] ce_f, ceh_f;
  logic       ready_f;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 ci = ~ci;

  // Channel 0 = 16'h4000 (every 4 cycles), channel 1 = 16'h8000 (every 2 cycles).
  mmcm_cegen #(
    .N          (2),
    .W          (16),
    .INC        ({16'h8000, 16'h4000}),
    .LOCK_CYCLES(LcM)
  ) dut_m (
    .ci_i    (ci),
    .reset_ni(reset_n),
    .locked_i(locked),
    .sync_i  (sync),
    .halt_i  (halt_m),
    .ce_o    (ce_m),
    .ceh_o   (ceh_m),
    .ready_o (ready_m)
  );

  mmcm_cegen #(
    .N          (1),
    .W          (8),
    .INC        (8'd3),
    .LOCK_CYCLES(LcF)
  ) dut_f (
    .ci_i    (ci),
    .reset_ni(reset_n),
    .locked_i(locked),
    .sync_i  (sync),
    .halt_i  (halt_f),
    .ce_o    (ce_f),
    .ceh_o   (ceh_f),
    .ready_o (ready_f)
  );

  // Reference model: per channel, k = number of accumulating steps since the last clear;
  // a carry happens when floor(k*inc/2^W) steps up, a half strobe when the same holds
  // with a half-turn offset.
  bit     m_ready [2];
  int     m_cnt   [2];
  longint m_k     [3];
  bit     e_ce    [3];
  bit     e_ceh   [3];
  longint ch_inc  [3] = '{64'h4000, 64'h8000, 64'd3};
  int     ch_w    [3] = '{16, 16, 8};
  int     ch_inst [3] = '{0, 0, 1};

  bit track_f = 1'b0;
  int f_cyc = 0, f_cnt = 0, f_first = 0, f_last = 0, f_badgap = 0;

  function automatic bit crosses(input longint k, input longint inc, input int w,
                                 input longint off);
    return (((k * inc) + off) >> w) != ((((k - 1) * inc) + off) >> w);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ready[i] = 1'b0;
      m_cnt[i]   = 0;
    end
    for (int c = 0; c < 3; c++) begin
      m_k[c]   = 0;
      e_ce[c]  = 1'b0;
      e_ceh[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit upd [2];
    for (int i = 0; i < 2; i++) begin
      int lc;
      lc     = (i == 0) ? LcM : LcF;
      upd[i] = 1'b0;
      if (!reset_n) begin
        m_ready[i] = 1'b0;
        m_cnt[i]   = 0;
      end else if (!m_ready[i]) begin
        if (locked) begin
          m_cnt[i]++;
          if (m_cnt[i] >= lc) begin
            m_ready[i] = 1'b1;
            upd[i]     = 1'b1;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end else if (!locked) begin
        m_ready[i] = 1'b0;
        m_cnt[i]   = 0;
      end else begin
        upd[i] = 1'b1;
      end
    end
    for (int c = 0; c < 3; c++) begin
      bit     h;
      longint half;
      if (c == 0) h = halt_m[0];
      else if (c == 1) h = halt_m[1];
      else h = halt_f[0];
      half     = longint'(1) << (ch_w[c] - 1);
      e_ce[c]  = 1'b0;
      e_ceh[c] = 1'b0;
      if (!upd[ch_inst[c]] || sync) begin
        m_k[c] = 0;
      end else if (!h) begin
        m_k[c]++;
        e_ce[c]  = crosses(m_k[c], ch_inc[c], ch_w[c], 0);
        e_ceh[c] = (ch_inc[c] < half) && crosses(m_k[c], ch_inc[c], ch_w[c], half);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model on the edge, compare all outputs 1 time unit later.
  task automatic tick();
    @(posedge ci);
    model_edge();
    #1;
    check("ready_m", 32'(ready_m), 32'(m_ready[0]));
    check("ce_m0", 32'(ce_m[0]), 32'(e_ce[0]));
    check("ce_m1", 32'(ce_m[1]), 32'(e_ce[1]));
    check("ceh_m0", 32'(ceh_m[0]), 32'(e_ceh[0]));
    check("ceh_m1", 32'(ceh_m[1]), 32'(e_ceh[1]));
    check("ready_f", 32'(ready_f), 32'(m_ready[1]));
    check("ce_f", 32'(ce_f[0]), 32'(e_ce[2]));
    check("ceh_f", 32'(ceh_f[0]), 32'(e_ceh[2]));
    if (track_f) begin
      f_cyc++;
      if (ce_f[0] === 1'b1) begin
        f_cnt++;
        if (f_last == 0) f_first = f_cyc;
        else if ((f_cyc - f_last) != 85 && (f_cyc - f_last) != 86) f_badgap++;
        f_last = f_cyc;
      end
    end
  endtask

  task automatic wait_ce0(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ce_m[0] !== 1'b1 && n < limit);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, c1, h0, h1, hp;
    model_reset();

    // Reset state.
    repeat (3) tick();
    check("rst_ce_m", 32'(ce_m), 0);
    check("rst_ready_m", 32'(ready_m), 0);
    reset_n = 1'b1;
    repeat (10) tick();

    // Lock glitch at count 10, then a full wait from the re-high.
    locked = 1'b1;
    repeat (10) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    n = 0;
    while (ready_m !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("lock_wait_m", n, 16);

    // Rates over RUN cycles 2..41.
    c0 = 0; c1 = 0; h0 = 0; h1 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      c0 += int'(ce_m[0]); c1 += int'(ce_m[1]);
      h0 += int'(ceh_m[0]); h1 += int'(ceh_m[1]);
    end
    check("rate_ce0", c0, 10);
    check("rate_ce1", c1, 20);
    check("rate_ceh0", h0, 10);
    check("rate_ceh1", h1, 0);

    // Halt channel 0 for 5 cycles right after a pulse.
    wait_ce0(20, n);
    check("align_halt", 32'(ce_m[0]), 1);
    halt_m = 2'b01;
    hp = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      hp += int'(ce_m[0]) + int'(ceh_m[0]);
    end
    halt_m = 2'b00;
    check("halt_no_pulse", hp, 0);
    wait_ce0(20, n);
    check("halt_stretch", n + 5, 9);

    // sync together with halt on the cycle channel 0 would carry.
    repeat (3) tick();
    sync   = 1'b1;
    halt_m = 2'b01;
    tick();
    check("sync_no_pulse", 32'(ce_m), 0);
    sync   = 1'b0;
    halt_m = 2'b00;
    check("sync_acc0", 32'(dut_m.g_ch[0].u_acc.acc_q), 0);
    check("sync_acc1", 32'(dut_m.g_ch[1].u_acc.acc_q), 0);
    wait_ce0(20, n);
    check("sync_rephase", n, 4);

    // Random halt/sync traffic against the model.
    for (int i = 0; i < 300; i++) begin
      halt_m = 2'($urandom);
      halt_f = 1'($urandom);
      sync   = ($urandom_range(0, 15) == 0);
      tick();
    end
    halt_m = 2'b00;
    halt_f = 1'b0;
    sync   = 1'b0;

    // Lock loss in RUN.
    tick();
    locked = 1'b0;
    tick();
    check("drop_ready", 32'(ready_m), 0);
    check("drop_ce", 32'(ce_m), 0);
    check("drop_acc0", 32'(dut_m.g_ch[0].u_acc.acc_q), 0);
    check("drop_acc1", 32'(dut_m.g_ch[1].u_acc.acc_q), 0);
    locked = 1'b1;
    n = 0;
    while (ready_f !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("lock_wait_f", n, 4);

    // Fractional channel over 2560 RUN cycles.
    f_cyc   = 1;
    track_f = 1'b1;
    repeat (2559) tick();
    track_f = 1'b0;
    check("frac_count", f_cnt, 30);
    check("frac_first", f_first, 86);
    check("frac_gaps", f_badgap, 0);
    check("frac_last", f_last, 2560);

    // Asynchronous reset between edges while a pulse is high.
    n = 0;
    while (ce_m[1] !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check("align_rst", 32'(ce_m[1]), 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_ce", 32'(ce_m), 0);
    check("arst_ceh", 32'(ceh_m), 0);
    check("arst_ready_m", 32'(ready_m), 0);
    check("arst_ready_f", 32'(ready_f), 0);
    model_reset();
    tick();
    reset_n = 1'b1;
    n = 0;
    while (ready_m !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("relock_wait_m", n, 16);
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
